// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and helpers.
// Tap masks, feedback parity, zero check, meter control bundle.
package lfsr_pkg;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic restart;
    logic clearMeas;
    logic step;
  } meterCtl_t;

  // Bit i set means x^i appears in the primitive polynomial.
  function automatic logic [15:0] defaultTaps(input int w);
    logic [15:0] t;
    case (w)
      4:       t = 16'h0009;
      5:       t = 16'h0009;
      6:       t = 16'h0021;
      7:       t = 16'h0041;
      8:       t = 16'h0071;
      9:       t = 16'h0021;
      10:      t = 16'h0081;
      11:      t = 16'h0201;
      12:      t = 16'h0053;
      13:      t = 16'h001B;
      14:      t = 16'h002B;
      15:      t = 16'h4001;
      16:      t = 16'hA011;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  function automatic logic feedbackParity(
    input logic [MAX_W-1:0] st,
    input logic [MAX_W-1:0] taps
  );
    return ^(st & taps);
  endfunction

  function automatic logic isZero(input logic [MAX_W-1:0] st);
    return st == '0;
  endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Period meter: start value, saturating step count, wrap pulse.
// In: clk, rst, ctl, restartVal, nextState. Out: wrap, periodLen, periodValid.
module lfsr_period_meter
  import lfsr_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter int              CNT_W    = WIDTH,
  parameter logic [WIDTH-1:0] INIT_VAL = 8'h80
) (
  input  logic             clk,
  input  logic             rst,
  input  meterCtl_t        ctl,
  input  logic [WIDTH-1:0] restartVal,
  input  logic [WIDTH-1:0] nextState,
  output logic             wrap,
  output logic [CNT_W-1:0] periodLen,
  output logic             periodValid
);

  logic [WIDTH-1:0] startVal;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntInc;

  assign cntInc = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      startVal    <= INIT_VAL;
      cnt         <= '0;
      wrap        <= 1'b0;
      periodLen   <= '0;
      periodValid <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (ctl.restart) begin
        startVal <= restartVal;
        cnt      <= '0;
        if (ctl.clearMeas) begin
          periodLen   <= '0;
          periodValid <= 1'b0;
        end
      end else if (ctl.step) begin
        if (nextState == startVal) begin
          wrap        <= 1'b1;
          periodLen   <= cntInc;
          periodValid <= 1'b1;
          cnt         <= '0;
        end else begin
          cnt <= cntInc;
        end
      end
    end
  end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Fibonacci LFSR PRBS source with seed load, lock-up recovery, period meter.
// In: clk, rst, sync_init, load, seed, en. Out: state, ser_out, wrap, lockup, period_len, period_valid.
module lfsr_prbs_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = 8'h71,
  parameter logic [WIDTH-1:0] INIT_VAL = 8'h80,
  parameter int               CNT_W    = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_init,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] state,
  output logic             ser_out,
  output logic             wrap,
  output logic             lockup,
  output logic [CNT_W-1:0] period_len,
  output logic             period_valid
);

  logic             fb;
  logic             stateZero;
  logic [WIDTH-1:0] nextState;
  logic             doInit;
  logic             doLoad;
  logic             doRecover;
  logic             doStep;
  meterCtl_t        ctl;
  logic [WIDTH-1:0] restartVal;

  assign fb        = feedbackParity(MAX_W'(state), MAX_W'(TAPS));
  assign stateZero = isZero(MAX_W'(state));
  assign nextState = {fb, state[WIDTH-1:1]};
  assign ser_out   = state[0];

  assign doInit    = sync_init;
  assign doLoad    = !sync_init && load;
  assign doRecover = !sync_init && !load && en && stateZero;
  assign doStep    = !sync_init && !load && en && !stateZero;

  // Recovery restarts the meter but keeps the last measurement.
  assign ctl.restart   = doInit || doLoad || doRecover;
  assign ctl.clearMeas = doInit || doLoad;
  assign ctl.step      = doStep;
  assign restartVal    = doLoad ? seed : INIT_VAL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= INIT_VAL;
      lockup <= 1'b0;
    end else begin
      lockup <= doRecover;
      unique case (1'b1)
        doInit:    state <= INIT_VAL;
        doLoad:    state <= seed;
        doRecover: state <= INIT_VAL;
        doStep:    state <= nextState;
        default:   state <= state;
      endcase
    end
  end

  lfsr_period_meter #(
    .WIDTH    (WIDTH),
    .CNT_W    (CNT_W),
    .INIT_VAL (INIT_VAL)
  ) uMeter (
    .clk         (clk),
    .rst         (rst),
    .ctl         (ctl),
    .restartVal  (restartVal),
    .nextState   (nextState),
    .wrap        (wrap),
    .periodLen   (period_len),
    .periodValid (period_valid)
  );

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboard bench for lfsr_prbs_gen (default 8-bit build).
// Stimulus pushes expectations; monitor pops one per clock.
module tb_lfsr_prbs_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync_init = 1'b0;
  logic       load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       en = 1'b0;
  logic [7:0] state;
  logic       ser_out;
  logic       wrap;
  logic       lockup;
  logic [7:0] period_len;
  logic       period_valid;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] st;
    logic       wr;
    logic       lk;
    logic [7:0] pl;
    logic       pv;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  logic [7:0] mSt, mStart, mCnt, mLen;
  logic       mVal, mWrap, mLock;

  always #5 clk = ~clk;

  lfsr_prbs_gen dut (
    .clk          (clk),
    .rst          (rst),
    .sync_init    (sync_init),
    .load         (load),
    .seed         (seed),
    .en           (en),
    .state        (state),
    .ser_out      (ser_out),
    .wrap         (wrap),
    .lockup       (lockup),
    .period_len   (period_len),
    .period_valid (period_valid)
  );

  task automatic resetModel();
    mSt = 8'h80; mStart = 8'h80; mCnt = 8'h00;
    mLen = 8'h00; mVal = 1'b0; mWrap = 1'b0; mLock = 1'b0;
  endtask

  task automatic doCycle(input logic si, input logic ld,
                         input logic [7:0] sd, input logic e,
                         input string nm);
    logic [7:0] nx;
    @(negedge clk);
    sync_init = si; load = ld; seed = sd; en = e;
    mWrap = 1'b0; mLock = 1'b0;
    if (si) begin
      mSt = 8'h80; mStart = 8'h80; mCnt = 0; mLen = 0; mVal = 0;
    end else if (ld) begin
      mSt = sd; mStart = sd; mCnt = 0; mLen = 0; mVal = 0;
    end else if (e && mSt == 8'h00) begin
      mSt = 8'h80; mStart = 8'h80; mCnt = 0; mLock = 1'b1;
    end else if (e) begin
      nx = {mSt[0] ^ mSt[4] ^ mSt[5] ^ mSt[6], mSt[7:1]};
      mSt = nx;
      if (nx == mStart) begin
        mWrap = 1'b1;
        mLen = (mCnt == 8'hFF) ? 8'hFF : mCnt + 8'd1;
        mVal = 1'b1;
        mCnt = 0;
      end else begin
        mCnt = (mCnt == 8'hFF) ? 8'hFF : mCnt + 8'd1;
      end
    end
    sb.push_back('{mSt, mWrap, mLock, mLen, mVal, nm});
  endtask

  // Replace the last pushed expectation with hand-derived values.
  task automatic hand(input logic [7:0] st, input logic wr,
                      input logic lk, input logic [7:0] pl,
                      input logic pv, input string nm);
    int k = sb.size() - 1;
    sb[k].st = st; sb[k].wr = wr; sb[k].lk = lk;
    sb[k].pl = pl; sb[k].pv = pv; sb[k].nm = nm;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        checks++;
        if ({state, ser_out, wrap, lockup, period_len, period_valid} !==
            {cur.st, cur.st[0], cur.wr, cur.lk, cur.pl, cur.pv}) begin
          failures++;
          $display("FAIL %s: got st=%h ser=%b wrap=%b lock=%b plen=%0d pv=%b; want st=%h ser=%b wrap=%b lock=%b plen=%0d pv=%b",
                   cur.nm, state, ser_out, wrap, lockup, period_len,
                   period_valid, cur.st, cur.st[0], cur.wr, cur.lk,
                   cur.pl, cur.pv);
        end
      end
    end
  end

  initial begin
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    doCycle(0, 0, 8'h00, 0, "reset");
    hand(8'h80, 0, 0, 8'd0, 0, "reset");

    for (int i = 1; i <= 510; i++) begin
      doCycle(0, 0, 8'h00, 1, "run");
      if (i == 1)   hand(8'h40, 0, 0, 8'd0, 0, "step1");
      if (i == 2)   hand(8'hA0, 0, 0, 8'd0, 0, "step2");
      if (i == 3)   hand(8'hD0, 0, 0, 8'd0, 0, "step3");
      if (i == 4)   hand(8'h68, 0, 0, 8'd0, 0, "step4");
      if (i == 255) hand(8'h80, 1, 0, 8'd255, 1, "wrap1");
      if (i == 256) hand(8'h40, 0, 0, 8'd255, 1, "afterWrap1");
      if (i == 510) hand(8'h80, 1, 0, 8'd255, 1, "wrap2");
    end

    for (int i = 0; i < 5; i++) doCycle(0, 0, 8'h00, 1, "mid");
    doCycle(1, 1, 8'h5A, 1, "initWins");
    hand(8'h80, 0, 0, 8'd0, 0, "initWins");
    doCycle(0, 0, 8'h00, 0, "initHold");
    hand(8'h80, 0, 0, 8'd0, 0, "initHold");

    doCycle(0, 1, 8'h00, 0, "loadZero");
    hand(8'h00, 0, 0, 8'd0, 0, "loadZero");
    doCycle(0, 0, 8'h00, 1, "lockup");
    hand(8'h80, 0, 1, 8'd0, 0, "lockup");
    doCycle(0, 0, 8'h00, 1, "afterLockup");
    hand(8'h40, 0, 0, 8'd0, 0, "afterLockup");

    doCycle(0, 1, 8'h5A, 0, "load5A");
    hand(8'h5A, 0, 0, 8'd0, 0, "load5A");
    for (int n = 1; n <= 255; n++) begin
      doCycle(0, 0, 8'h00, 0, "gapOff");
      if (n == 1) hand(8'h5A, 0, 0, 8'd0, 0, "gapHold");
      doCycle(0, 0, 8'h00, 1, "gapOn");
      if (n == 1)   hand(8'h2D, 0, 0, 8'd0, 0, "gapStep1");
      if (n == 255) hand(8'h5A, 1, 0, 8'd255, 1, "gapWrap");
    end
    doCycle(0, 0, 8'h00, 0, "gapAfter");
    hand(8'h5A, 0, 0, 8'd255, 1, "gapAfter");

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
